pe_rf_wr_arbiter: RTL and testbench

Round-robin write-port arbiter for the shared register file of a PE cluster. It sits between the four PEs of a cluster and the single write port of the cluster register file. Each PE gets a small request buffer, so its ready does not depend combinationally on the grant. The arbiter issues at most one registered write per cycle, grants fairly, and supports a stall input from the register file side.

---
 rtl/pe_rf_wr_arbiter_if.sv | 29 ++
 rtl/pe_rf_wr_arbiter.sv | 109 ++++++++++
 tb/tb_pe_rf_wr_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_rf_wr_arbiter_if.sv
// rtl/pe_rf_wr_arbiter_if.sv - PE request bus and register-file write port bundle
interface pe_rf_wr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_data;
  logic                rf_stall;
  logic                rf_we;
  logic [AW-1:0]       rf_waddr;
  logic [DW-1:0]       rf_wdata;
  logic [IDW-1:0]      rf_grant_id;
  logic [N_REQ-1:0]    pend;

  modport master (
    output req_valid, req_addr, req_data, rf_stall,
    input  req_ready, rf_we, rf_waddr, rf_wdata, rf_grant_id, pend
  );

  modport slave (
    input  req_valid, req_addr, req_data, rf_stall,
    output req_ready, rf_we, rf_waddr, rf_wdata, rf_grant_id, pend
  );
endinterface

// File: rtl/pe_rf_wr_arbiter.sv
// rtl/pe_rf_wr_arbiter.sv - round-robin arbiter of buffered PE writes onto one register-file write port
module pe_rf_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int AW    = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input logic                clk,
  input logic                rst,
  pe_rf_wr_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(DEPTH + 1);

  logic [CW-1:0]    count      [N_REQ];
  logic [CW-1:0]    count_next [N_REQ];
  logic [CW-1:0]    wr_idx     [N_REQ];
  logic [AW-1:0]    mem_addr   [N_REQ][DEPTH];
  logic [DW-1:0]    mem_data   [N_REQ][DEPTH];
  logic [N_REQ-1:0] push;
  logic [N_REQ-1:0] pop;
  logic [N_REQ-1:0] nonempty;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   idx;
  logic             grant_valid;

  logic [N_REQ-1:0] req_ready_q;
  logic [N_REQ-1:0] pend_q;
  logic             rf_we_q;
  logic [AW-1:0]    rf_waddr_q;
  logic [DW-1:0]    rf_wdata_q;
  logic [IDW-1:0]   rf_grant_id_q;

  always_comb begin
    grant_valid = 1'b0;
    winner      = '0;
    idx         = '0;
    for (int i = 0; i < N_REQ; i++) begin
      nonempty[i] = (count[i] != '0);
      push[i]     = bus.req_valid[i] && req_ready_q[i];
    end
    // First non-empty FIFO at or after rr_ptr wins; the pointer width wraps the search.
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_ptr + IDW'(k);
      if (!grant_valid && nonempty[idx]) begin
        grant_valid = 1'b1;
        winner      = idx;
      end
    end
    if (bus.rf_stall) grant_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      pop[i]        = grant_valid && (winner == IDW'(i));
      count_next[i] = count[i] + CW'(push[i]) - CW'(pop[i]);
      wr_idx[i]     = pop[i] ? (count[i] - CW'(1)) : count[i];
    end
  end

  // Shift-register FIFOs: the head always sits at slot 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < DEPTH - 1; j++) begin
        if (pop[i]) begin
          mem_addr[i][j] <= mem_addr[i][j+1];
          mem_data[i][j] <= mem_data[i][j+1];
        end
      end
      for (int j = 0; j < DEPTH; j++) begin
        if (push[i] && (CW'(j) == wr_idx[i])) begin
          mem_addr[i][j] <= bus.req_addr[i*AW +: AW];
          mem_data[i][j] <= bus.req_data[i*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) count[i] <= '0;
      rr_ptr        <= '0;
      req_ready_q   <= '0;
      pend_q        <= '0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      rf_grant_id_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        count[i]       <= count_next[i];
        req_ready_q[i] <= (count_next[i] < CW'(DEPTH));
        pend_q[i]      <= (count_next[i] != '0);
      end
      rf_we_q <= grant_valid;
      if (grant_valid) begin
        rf_waddr_q    <= mem_addr[winner][0];
        rf_wdata_q    <= mem_data[winner][0];
        rf_grant_id_q <= winner;
        rr_ptr        <= winner + IDW'(1);
      end
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.pend        = pend_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.rf_grant_id = rf_grant_id_q;
endmodule

// File: tb/tb_pe_rf_wr_arbiter.sv
// tb/tb_pe_rf_wr_arbiter.sv - scoreboard bench for the PE register-file write arbiter
module tb_pe_rf_wr_arbiter;
  localparam int N     = 4;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pe_rf_wr_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus();

  pe_rf_wr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } wr_t;

  wr_t pe_q [N][$];
  wr_t exp_q[$];
  int  grant_log[$];
  int  m_ptr;
  logic m_we;
  logic [N-1:0] m_ready;
  logic [N-1:0] m_pend;
  wr_t m_last;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-PE queues, rotating search pointer, one grant per unstalled edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) pe_q[i].delete();
      exp_q.delete();
      m_ptr   = 0;
      m_we    = 1'b0;
      m_ready = '0;
      m_pend  = '0;
      m_last  = '0;
    end else begin : model_step
      logic [N-1:0] acc;
      int w;
      wr_t e;
      acc = bus.req_valid & m_ready;
      w = -1;
      if (!bus.rf_stall)
        for (int k = 0; k < N; k++)
          if (w < 0 && pe_q[(m_ptr + k) % N].size() > 0) w = (m_ptr + k) % N;
      m_we = (w >= 0);
      if (w >= 0) begin
        m_last = pe_q[w].pop_front();
        exp_q.push_back(m_last);
        m_ptr = (w + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          e.id   = i[IDW-1:0];
          e.addr = bus.req_addr[i*AW +: AW];
          e.data = bus.req_data[i*DW +: DW];
          pe_q[i].push_back(e);
        end
      end
      for (int i = 0; i < N; i++) begin
        m_ready[i] = (pe_q[i].size() < DEPTH);
        m_pend[i]  = (pe_q[i].size() != 0);
      end
    end
  end

  // Monitor: pops the scoreboard on every observed write and checks held state otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_we", 64'(bus.rf_we), 64'd0);
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_pend", 64'(bus.pend), 64'd0);
    end else begin : mon
      wr_t e;
      chk("rf_we", 64'(bus.rf_we), 64'(m_we));
      if (bus.rf_we === 1'b1) begin
        grant_log.push_back(int'(bus.rf_grant_id));
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(bus.rf_waddr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(bus.rf_waddr), 64'(e.addr));
          chk("wr_data", 64'(bus.rf_wdata), 64'(e.data));
          chk("wr_id", 64'(bus.rf_grant_id), 64'(e.id));
        end
      end else begin
        chk("hold_addr", 64'(bus.rf_waddr), 64'(m_last.addr));
        chk("hold_data", 64'(bus.rf_wdata), 64'(m_last.data));
        chk("hold_id", 64'(bus.rf_grant_id), 64'(m_last.id));
      end
      chk("req_ready", 64'(bus.req_ready), 64'(m_ready));
      chk("pend", 64'(bus.pend), 64'(m_pend));
    end
  end

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic randomize_bus();
    for (int i = 0; i < N; i++) set_req(i, AW'($urandom), $urandom);
  endtask

  task automatic cyc(input logic [N-1:0] v, input logic s);
    bus.req_valid = v;
    bus.rf_stall  = s;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    #2 rst = 1'b0;
    bus.req_valid = '0;
    bus.rf_stall  = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin : stim
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 1, 3};
    bus.req_valid = '0;
    bus.rf_stall  = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    repeat (2) @(negedge clk);
    chk("reset_we", 64'(bus.rf_we), 64'd0);
    chk("reset_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("reset_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("reset_gid", 64'(bus.rf_grant_id), 64'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(bus.req_ready), 64'hF);

    // Single request from PE2
    set_req(2, 4'd5, 32'hDEADBEEF);
    cyc(4'b0100, 1'b0);
    chk("single_not_yet", 64'(bus.rf_we), 64'd0);
    chk("single_pend", 64'(bus.pend), 64'b0100);
    cyc(4'b0000, 1'b0);
    chk("single_we", 64'(bus.rf_we), 64'd1);
    chk("single_addr", 64'(bus.rf_waddr), 64'd5);
    chk("single_data", 64'(bus.rf_wdata), 64'hDEADBEEF);
    chk("single_id", 64'(bus.rf_grant_id), 64'd2);
    cyc(4'b0000, 1'b0);
    chk("single_we_drop", 64'(bus.rf_we), 64'd0);

    // Round robin from a fresh pointer
    apply_reset();
    grant_log.delete();
    for (int i = 0; i < N; i++) set_req(i, AW'(i), $urandom);
    cyc(4'b1111, 1'b0);
    repeat (6) cyc(4'b0000, 1'b0);
    randomize_bus();
    cyc(4'b1010, 1'b0);
    repeat (4) cyc(4'b0000, 1'b0);
    chk("rr_count", 64'(grant_log.size()), 64'd6);
    for (int k = 0; k < 6; k++)
      if (k < grant_log.size()) chk("rr_order", 64'(grant_log[k]), 64'(exp_order[k]));

    // Backpressure with stall
    for (int c = 0; c < 4; c++) begin
      randomize_bus();
      cyc(4'b0001, 1'b1);
      if (c == 1) begin
        chk("bp_ready0", 64'(bus.req_ready[0]), 64'd0);
        chk("bp_pend0", 64'(bus.pend[0]), 64'd1);
      end
    end
    cyc(4'b0000, 1'b0);
    chk("bp_release_we", 64'(bus.rf_we), 64'd1);
    cyc(4'b0000, 1'b0);
    chk("bp_ready_back", 64'(bus.req_ready[0]), 64'd1);
    repeat (3) cyc(4'b0000, 1'b0);

    // Stall mid-stream across three requesters
    randomize_bus();
    cyc(4'b0111, 1'b0);
    randomize_bus();
    cyc(4'b0111, 1'b0);
    cyc(4'b0000, 1'b1);
    chk("stall_no_we0", 64'(bus.rf_we), 64'd0);
    cyc(4'b0000, 1'b1);
    chk("stall_no_we1", 64'(bus.rf_we), 64'd0);
    repeat (8) cyc(4'b0000, 1'b0);

    // Reset with five entries buffered
    randomize_bus();
    cyc(4'b0111, 1'b1);
    randomize_bus();
    cyc(4'b0011, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_we", 64'(bus.rf_we), 64'd0);
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    chk("mid_rst_pend", 64'(bus.pend), 64'd0);
    chk("mid_rst_addr", 64'(bus.rf_waddr), 64'd0);
    chk("mid_rst_data", 64'(bus.rf_wdata), 64'd0);
    bus.req_valid = '0;
    bus.rf_stall  = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_back", 64'(bus.req_ready), 64'hF);
    repeat (4) cyc(4'b0000, 1'b0);

    // Continuous push/pop on PE1
    for (int c = 0; c < 8; c++) begin
      randomize_bus();
      cyc(4'b0010, 1'b0);
      if (c > 1) chk("pp_pend1", 64'(bus.pend[1]), 64'd1);
    end
    repeat (3) cyc(4'b0000, 1'b0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      randomize_bus();
      cyc(N'($urandom), ($urandom_range(0, 3) == 0));
    end
    repeat (12) cyc(4'b0000, 1'b0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
